// File: rtl/stream_demux_pkg.sv
// ============================================================================
// Module   : stream_demux_pkg
// Brief    : Shared types, limits and helpers for the stream_demux block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Minimum select width able to address n channels (never below 1 bit).
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_chan_reg.sv
// ============================================================================
// Module   : demux_chan_reg
// Brief    : One-entry valid/ready holding register for a single demux output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_chan_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;

  // A load wins over a drain, so a same-cycle load+drain keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// Module   : stream_demux
// Brief    : 1-to-NUM_CH packet demultiplexer with per-channel output stages.
//            Define STREAM_DEMUX_DROP_INVALID_SEL_EN to drop packets whose
//            select is out of range instead of routing them to the last channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_last,
  output logic                     busy,
  output logic                     err_drop
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  if ((NUM_CH < 2) || (NUM_CH > MAX_CH)) begin : g_bad_num_ch
    $error("stream_demux: NUM_CH must be in 2..%0d", MAX_CH);
  end
  if (SEL_W < sel_width(NUM_CH)) begin : g_bad_sel_w
    $error("stream_demux: SEL_W too narrow for NUM_CH");
  end

  state_e            state_q;
  logic [SEL_W-1:0]  cur_sel_q;
  logic              err_drop_q;

  logic [SEL_W-1:0]  w_sel_raw;
  logic [SEL_W-1:0]  w_tgt;
  logic              w_oor;
  logic              w_drop;
  logic              w_tgt_ready;
  logic              w_accept;
  logic [NUM_CH-1:0] w_load;

  // The raw select is kept in cur_sel_q, so out-of-range handling is simply
  // re-evaluated on every beat of the locked packet.
  assign w_sel_raw = (state_q == ST_LOCKED) ? cur_sel_q : in_sel;

  if (NUM_CH == (1 << SEL_W)) begin : g_sel_full
    assign w_oor = 1'b0;
  end else begin : g_sel_part
    assign w_oor = (w_sel_raw > LAST_CH);
  end

`ifdef STREAM_DEMUX_DROP_INVALID_SEL_EN
  assign w_drop = w_oor;
`else
  assign w_drop = 1'b0;
`endif

  assign w_tgt = w_oor ? LAST_CH : w_sel_raw;

  always_comb begin
    w_tgt_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_tgt == SEL_W'(k)) begin
        w_tgt_ready = !out_valid[k] || out_ready[k];
      end
    end
  end

  assign in_ready = rst_n & (w_drop | w_tgt_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_sel_q  <= '0;
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= w_accept & w_drop;
      if (w_accept) begin
        case (state_q)
          ST_IDLE: begin
            cur_sel_q <= in_sel;
            if (!in_last) begin
              state_q <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (in_last) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_q == ST_LOCKED);
  assign err_drop = err_drop_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign w_load[k] = w_accept & ~w_drop & (w_tgt == SEL_W'(k));

    demux_chan_reg #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (w_load[k]),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*DATA_W +: DATA_W]),
      .last_o  (out_last[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// Module   : tb_stream_demux
// Brief    : Scoreboard bench for stream_demux (3 channels, 2-bit select).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_stream_demux;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data = '0;
  logic [SEL_W-1:0]         in_sel = '0;
  logic                     in_last = 1'b0;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready = '1;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_last;
  logic                     busy;
  logic                     err_drop;

  stream_demux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                cyc;
  } beat_t;

  beat_t exp_q [NUM_CH][$];
  int    drop_q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model state: packet-level view of the stream.
  bit               in_pkt = 1'b0;
  logic [SEL_W-1:0] pkt_sel = '0;
  logic [SEL_W-1:0] m_sel;
  bit               m_oor, m_drop;
  int               m_ch;
  bit               mon_ev;
  beat_t            m_beat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // A beat accepted on an earlier edge sits in the channel's one-entry stage.
  function automatic bit occupied(input int k);
    return (exp_q[k].size() > 0) && (exp_q[k][0].cyc < cyc);
  endfunction

  function automatic logic [DATA_W-1:0] chd(input int k);
    return out_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    drop_q.delete();
    in_pkt = 1'b0;
  endtask

  // Stimulus-side model: predicts in_ready/busy and pushes expected beats.
  always @(negedge clk) begin
    if (rst_n) begin
      m_sel = in_pkt ? pkt_sel : in_sel;
      m_oor = (int'(m_sel) >= NUM_CH);
`ifdef STREAM_DEMUX_DROP_INVALID_SEL_EN
      m_drop = m_oor;
`else
      m_drop = 1'b0;
`endif
      m_ch = m_oor ? NUM_CH - 1 : int'(m_sel);
      chk("busy", 32'(busy), 32'(in_pkt));
      chk("in_ready", 32'(in_ready), 32'(m_drop || !occupied(m_ch) || out_ready[m_ch]));
      if (in_valid && in_ready) begin
        if (m_drop) begin
          drop_q.push_back(cyc);
        end else begin
          m_beat.data = in_data;
          m_beat.last = in_last;
          m_beat.cyc  = cyc;
          exp_q[m_ch].push_back(m_beat);
        end
        if (!in_pkt) pkt_sel = in_sel;
        in_pkt = !in_last;
      end
    end
  end

  // Output monitor: pops and compares whatever the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mon_ev = occupied(k);
        chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mon_ev));
        if (out_valid[k] && mon_ev) begin
          chk($sformatf("out_data[%0d]", k), 32'(chd(k)), 32'(exp_q[k][0].data));
          chk($sformatf("out_last[%0d]", k), 32'(out_last[k]), 32'(exp_q[k][0].last));
          if (out_ready[k]) void'(exp_q[k].pop_front());
        end
      end
      mon_ev = (drop_q.size() > 0) && (drop_q[0] < cyc);
      chk("err_drop", 32'(err_drop), 32'(mon_ev));
      if (err_drop && mon_ev) void'(drop_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int sel, input int data, input bit last);
    in_valid = v;
    in_sel   = SEL_W'(sel);
    in_data  = DATA_W'(data);
    in_last  = last;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-cycle with a beat pending
    drive(1, 0, 8'h3C, 0);
    tick();
    chk("t1_busy_pre", 32'(busy), 32'd1);
    chk("t1_valid_pre", 32'(out_valid), 32'b001);
    #2 rst_n = 1'b0;
    reset_model();
    #1;
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_ready", 32'(in_ready), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_err", 32'(err_drop), 32'd0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("t1_ready_rel", 32'(in_ready), 32'd1);

    // Single-beat packet
    drive(1, 1, 8'hA5, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("t2_valid", 32'(out_valid), 32'b010);
    chk("t2_data", 32'(chd(1)), 32'hA5);
    chk("t2_last", 32'(out_last[1]), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    tick();

    // Channel held for the whole packet
    drive(1, 0, 8'h11, 0);
    tick();
    chk("t3_busy1", 32'(busy), 32'd1);
    chk("t3_d1", 32'(chd(0)), 32'h11);
    drive(1, 1, 8'h22, 0);
    tick();
    chk("t3_valid2", 32'(out_valid), 32'b001);
    chk("t3_d2", 32'(chd(0)), 32'h22);
    drive(1, 1, 8'h33, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("t3_valid3", 32'(out_valid), 32'b001);
    chk("t3_d3", 32'(chd(0)), 32'h33);
    chk("t3_busy3", 32'(busy), 32'd0);
    tick();

    // Backpressure then same-cycle load and drain
    out_ready = 3'b110;
    drive(1, 0, 8'h44, 1);
    tick();
    drive(1, 0, 8'h55, 1);
    #1 chk("t4_ready_blk", 32'(in_ready), 32'd0);
    tick();
    chk("t4_held", 32'(chd(0)), 32'h44);
    out_ready[0] = 1'b1;
    #1 chk("t4_ready_go", 32'(in_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0);
    chk("t4_valid", 32'(out_valid[0]), 32'd1);
    chk("t4_data", 32'(chd(0)), 32'h55);
    tick();
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a packet
    drive(1, 2, 8'hD1, 0);
    tick();
    drive(1, 0, 8'hD2, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    chk("t5_valid_pre", 32'(out_valid), 32'b100);
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    drive(1, 1, 8'h5A, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("t5_new_head", 32'(out_valid), 32'b010);
    chk("t5_new_data", 32'(chd(1)), 32'h5A);
    tick();

    // Out-of-range select
    drive(1, 3, 8'h66, 0);
    tick();
`ifdef STREAM_DEMUX_DROP_INVALID_SEL_EN
    chk("t6_err1", 32'(err_drop), 32'd1);
    chk("t6_valid1", 32'(out_valid), 32'd0);
`else
    chk("t6_err1", 32'(err_drop), 32'd0);
    chk("t6_valid1", 32'(out_valid), 32'b100);
    chk("t6_data1", 32'(chd(2)), 32'h66);
`endif
    drive(1, 0, 8'h77, 1);
    tick();
    drive(0, 0, 0, 0);
`ifdef STREAM_DEMUX_DROP_INVALID_SEL_EN
    chk("t6_err2", 32'(err_drop), 32'd1);
    chk("t6_valid2", 32'(out_valid), 32'd0);
`else
    chk("t6_err2", 32'(err_drop), 32'd0);
    chk("t6_valid2", 32'(out_valid), 32'b100);
    chk("t6_data2", 32'(chd(2)), 32'h77);
`endif
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_err3", 32'(err_drop), 32'd0);

    // Randomised traffic with random backpressure and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sel    = SEL_W'($urandom_range(0, 3));
      in_data   = DATA_W'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = NUM_CH'($urandom);
      if (i == 1500) begin
        rst_n = 1'b0;
        reset_model();
        #1 chk("rnd_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      tick();
    end

    drive(0, 0, 0, 0);
    out_ready = '1;
    repeat (4) tick();
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("drain_q[%0d]", k), 32'(exp_q[k].size()), 32'd0);
    end
    chk("drain_drop", 32'(drop_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux.md
Name: stream_demux

Overview:
1-to-NUM_CH packet demultiplexer, the inverse of the team's 2:1 select mux. It routes one valid/ready input stream to one of NUM_CH output channels, chosen by in_sel. The channel is latched on the first beat of a packet and held until the in_last beat. Each output channel has a one-entry registered stage, so the block sits between a shared producer and independent per-channel consumers.

Parameters:
NUM_CH, 2, number of output channels (2..16)
DATA_W, 8, data width per beat
SEL_W, 1, select width; 2**SEL_W >= NUM_CH required

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid & in_ready
in_data  input  DATA_W  input beat data
in_sel  input  SEL_W  destination channel, sampled on first beat of packet
in_last  input  1  final beat of packet
out_valid  output  NUM_CH  per-channel valid
out_ready  input  NUM_CH  per-channel ready
out_data  output  NUM_CH*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
out_last  output  NUM_CH  per-channel last flag
busy  output  1  high while mid-packet (LOCKED)
err_drop  output  1  one-cycle pulse per dropped beat (feature-dependent)

Behaviour:
- Reset: clk single clock; rst_n asynchronous active-low. While rst_n=0: state=IDLE, out_valid=0, out_data=0, out_last=0, busy=0, err_drop=0, in_ready forced 0.
- FSM states: IDLE, LOCKED.
- IDLE: target = in_sel. On an accepted beat, cur_sel <= in_sel. If in_last=0, go to LOCKED; if in_last=1, stay in IDLE (single-beat packet).
- LOCKED: target = cur_sel; in_sel is ignored. On an accepted beat with in_last=1, go to IDLE. With in_valid=0, hold state.
- busy = (state==LOCKED).
- Channel register k:
  - load when an accepted beat targets k: out_data/out_last <= in_data/in_last, out_valid[k] <= 1.
  - else if out_valid[k] & out_ready[k]: out_valid[k] <= 0; data is held and not cleared.
  - Load and drain in the same cycle: out_valid stays 1 and the new data replaces the old (full throughput).
- in_ready = !out_valid[target] | out_ready[target]. This is a combinational path from out_ready, which is permitted.
- Latency: exactly 1 cycle from accept to out_valid. Throughput is 1 beat/cycle when the consumer is always ready.
- Non-target channels drain independently. Beat order within a channel is preserved, and no beat is ever duplicated or lost.
- Reset mid-packet: the partial packet is abandoned, registered beats are discarded, and state returns to IDLE.
- Out-of-range sel (in_sel >= NUM_CH, sampled in IDLE) is handled per the Optional Feature.

Optional Feature:
Macro: STREAM_DEMUX_DROP_INVALID_SEL_EN.
- Defined:
  - An out-of-range sel sets a drop flag for the packet.
  - in_ready=1 for all of its beats; beats are discarded.
  - err_drop pulses for each dropped beat.
  - The FSM still tracks in_last.
- Undefined:
  - An out-of-range sel is routed to channel NUM_CH-1.
  - err_drop is tied 0.

Decomposition:
- Package stream_demux_pkg holds:
  - the state enum typedef (ST_IDLE, ST_LOCKED);
  - a sel-width helper function (clog2 with minimum 1);
  - localparam MAX_CH=16.
- Sub-module demux_chan_reg: one-entry valid/ready holding register with load, drain and same-cycle load+drain. It is instantiated NUM_CH times in a generate loop.

Test Plan:
1. Assert rst_n=0 asynchronously mid-cycle with in_valid=1 -> out_valid=0, in_ready=0, busy=0 immediately. Release -> in_ready=1 on the next edge.
2. Single beat sel=1, data=0xA5, last=1, out_ready=all 1 -> the following cycle out_valid=2'b10, ch1 data=0xA5, out_last[1]=1, busy stays 0.
3. 3-beat packet 0x11,0x22,0x33 with sel=0 on beat 1 and in_sel=1 on beats 2-3 -> all three beats appear on ch0 in order, busy=1 after beat 1 until beat 3 is accepted, ch1 never valid.
4. out_ready[0]=0, two beats to ch0 -> first beat is held, in_ready=0 for the second. Raise out_ready[0] -> second beat accepted the same cycle, out_valid[0] stays 1, data updates to beat 2, no loss.
5. Reset mid-packet after beat 2 of 4 -> outputs cleared, next accepted beat is sampled as a new packet head using in_sel.
6. NUM_CH=3, SEL_W=2, sel=3, 2-beat packet -> with macro: both beats accepted, 2 err_drop pulses, no out_valid. Without macro: beats appear on ch2.
